// File: rtl/competition_view_multi_if.sv
// Bus between the top-level view mux and the competition view: round status
// flows in, seven-segment / LED / buzzer drive flows out.
interface competition_view_multi_if #(
    parameter int PLAYERS = 4,
    parameter int SCORE_W = 7,
    parameter int TIME_W  = 18
);
    logic                       enable;
    logic [3:0]                 play_count;
    logic [2:0]                 state;
    logic [TIME_W-1:0]          time_remain;
    logic [PLAYERS*SCORE_W-1:0] scores;
    logic [3:0]                 select_player;
    logic [3:0]                 winner;
    logic [7:0]                 seg_out;
    logic [7:0]                 seg_en;
    logic [PLAYERS-1:0]         led;
    logic                       buzzer;

    modport master (
        output enable, play_count, state, time_remain, scores, select_player, winner,
        input  seg_out, seg_en, led, buzzer
    );

    modport slave (
        input  enable, play_count, state, time_remain, scores, select_player, winner,
        output seg_out, seg_en, led, buzzer
    );
endinterface

// File: rtl/competition_view_multi.sv
// Competition view for a quiz round: scans an 8-digit seven-segment display,
// drives per-player LEDs and a length-controlled buzzer pulse.
module competition_view_multi #(
    parameter int PLAYERS  = 4,
    parameter int SCORE_W  = 7,
    parameter int TIME_W   = 18,
    parameter int SCAN_DIV = 100000,
    parameter int ROT_DIV  = 100000000,
    parameter int BEEP_LEN = 20000000
) (
    input  logic                     clk,
    input  logic                     rst,
    competition_view_multi_if.slave  bus
);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int ROT_W  = (ROT_DIV > 1) ? $clog2(ROT_DIV) : 1;
    localparam int BEEP_W = $clog2(2 * BEEP_LEN + 1);

    localparam logic [2:0] ST_SELECT = 3'd0;
    localparam logic [2:0] ST_ANSWER = 3'd1;
    localparam logic [2:0] ST_JUDGE  = 3'd2;
    localparam logic [2:0] ST_FINISH = 3'd3;

    localparam logic [7:0]        SEG_BLANK  = 8'hFF;
    localparam logic [7:0]        SEG_C      = 8'hC6;
    localparam logic [3:0]        PLAYERS_L  = 4'(PLAYERS);
    localparam logic [SCAN_W-1:0] SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [ROT_W-1:0]  ROT_LAST   = ROT_W'(ROT_DIV - 1);
    localparam logic [ROT_W-1:0]  ROT_HALF   = ROT_W'(ROT_DIV / 2 - 1);
    localparam logic [BEEP_W-1:0] BEEP_SHORT = BEEP_W'(BEEP_LEN);
    localparam logic [BEEP_W-1:0] BEEP_LONG  = BEEP_W'(2 * BEEP_LEN);

    function automatic logic [7:0] hex_seg(input logic [3:0] v);
        case (v)
            4'h0:    return 8'hC0;
            4'h1:    return 8'hF9;
            4'h2:    return 8'hA4;
            4'h3:    return 8'hB0;
            4'h4:    return 8'h99;
            4'h5:    return 8'h92;
            4'h6:    return 8'h82;
            4'h7:    return 8'hF8;
            4'h8:    return 8'h80;
            4'h9:    return 8'h90;
            4'hA:    return 8'h88;
            4'hB:    return 8'h83;
            4'hC:    return 8'hC6;
            4'hD:    return 8'hA1;
            4'hE:    return 8'h86;
            4'hF:    return 8'h8E;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Three score glyphs {hundreds, tens, units}, clamped to 999, leading zeros blanked.
    function automatic logic [23:0] score_glyphs(input logic [SCORE_W-1:0] s);
        logic [9:0] v;
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] u;
        logic [7:0] gh;
        logic [7:0] gt;
        v  = (32'(s) > 32'd999) ? 10'd999 : 10'(s);
        h  = 4'(v / 10'd100);
        t  = 4'((v / 10'd10) % 10'd10);
        u  = 4'(v % 10'd10);
        gh = (h != 4'd0) ? hex_seg(h) : SEG_BLANK;
        gt = ((h != 4'd0) || (t != 4'd0)) ? hex_seg(t) : SEG_BLANK;
        return {gh, gt, hex_seg(u)};
    endfunction

    function automatic logic [15:0] time_glyphs(input logic [TIME_W-1:0] ms);
        logic [31:0] secs;
        logic [6:0]  c;
        secs = 32'(ms) / 32'd1000;
        c    = (secs > 32'd99) ? 7'd99 : 7'(secs);
        return {hex_seg(4'(c / 7'd10)), hex_seg(4'(c % 7'd10))};
    endfunction

    function automatic logic is_player(input logic [3:0] p);
        return (p != 4'd0) && (p <= PLAYERS_L);
    endfunction

    logic [SCAN_W-1:0]  scan_cnt_q,   scan_cnt_d;
    logic [2:0]         scan_idx_q,   scan_idx_d;
    logic [ROT_W-1:0]   rot_cnt_q,    rot_cnt_d;
    logic [3:0]         rot_player_q, rot_player_d;
    logic               blink_q,      blink_d;
    logic [BEEP_W-1:0]  beep_cnt_q,   beep_cnt_d;
    logic [2:0]         last_state_q, last_state_d;
    logic [7:0]         seg_out_q,    seg_out_d;
    logic [7:0]         seg_en_q,     seg_en_d;
    logic [PLAYERS-1:0] led_q,        led_d;
    logic               buzzer_q,     buzzer_d;

    logic               entry_s;
    logic               short_trig_s;
    logic               sel_valid_s;
    logic [3:0]         rot_eff_s;
    logic [SCORE_W-1:0] sel_score_s;
    logic [SCORE_W-1:0] rot_score_s;
    logic [23:0]        sel_digits_s;
    logic [23:0]        rot_digits_s;
    logic [15:0]        time_digits_s;
    logic [PLAYERS-1:0] led_s;
    logic [7:0]         glyph_s [8];

    assign entry_s      = bus.enable && (bus.state == ST_FINISH) && (last_state_q != ST_FINISH);
    assign short_trig_s = bus.enable &&
                          (((last_state_q == ST_SELECT) && (bus.state == ST_ANSWER)) ||
                           ((last_state_q == ST_ANSWER) && (bus.state == ST_JUDGE)));
    assign sel_valid_s  = is_player(bus.select_player);
    // The entry cycle already shows player 1, matching the reload taking effect.
    assign rot_eff_s    = entry_s ? 4'd1 : rot_player_q;

    // Safe score lookup for the selected and the rotating player.
    always_comb begin
        sel_score_s = '0;
        rot_score_s = '0;
        for (int k = 1; k <= PLAYERS; k++) begin
            sel_score_s = (bus.select_player == 4'(k)) ? bus.scores[k*SCORE_W-1 -: SCORE_W] : sel_score_s;
            rot_score_s = (rot_eff_s == 4'(k)) ? bus.scores[k*SCORE_W-1 -: SCORE_W] : rot_score_s;
        end
    end

    assign sel_digits_s  = score_glyphs(sel_score_s);
    assign rot_digits_s  = score_glyphs(rot_score_s);
    assign time_digits_s = time_glyphs(bus.time_remain);

    // Player LED pattern for the current round state.
    always_comb begin
        led_s = '0;
        case (bus.state)
            ST_SELECT, ST_JUDGE: begin
                for (int k = 1; k <= PLAYERS; k++) begin
                    led_s[k-1] = (bus.select_player == 4'(k));
                end
            end
            ST_FINISH: begin
                for (int k = 1; k <= PLAYERS; k++) begin
                    led_s[k-1] = (bus.winner == 4'(k)) && blink_q;
                end
            end
            default: led_s = '0;
        endcase
    end

    // Glyph for every digit slot; the scan index picks one per cycle.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            glyph_s[i] = SEG_BLANK;
        end
        glyph_s[0] = SEG_C;
        glyph_s[1] = hex_seg(bus.play_count);
        glyph_s[2] = (bus.state <= ST_FINISH) ? hex_seg({1'b0, bus.state} + 4'd10) : SEG_BLANK;
        case (bus.state)
            ST_SELECT: begin
                if (bus.play_count == 4'd0) begin
                    glyph_s[4] = SEG_BLANK;
                end else if (bus.select_player == 4'd0) begin
                    glyph_s[4] = hex_seg(4'd0);
                end else if (sel_valid_s) begin
                    glyph_s[4] = hex_seg(bus.select_player);
                    glyph_s[5] = sel_digits_s[23:16];
                    glyph_s[6] = sel_digits_s[15:8];
                    glyph_s[7] = sel_digits_s[7:0];
                end else begin
                    glyph_s[4] = SEG_BLANK;
                end
            end
            ST_ANSWER: begin
                glyph_s[6] = time_digits_s[15:8];
                glyph_s[7] = time_digits_s[7:0];
            end
            ST_JUDGE: begin
                glyph_s[4] = sel_valid_s ? hex_seg(bus.select_player) : SEG_BLANK;
            end
            ST_FINISH: begin
                glyph_s[4] = hex_seg(rot_eff_s);
                glyph_s[5] = rot_digits_s[23:16];
                glyph_s[6] = rot_digits_s[15:8];
                glyph_s[7] = rot_digits_s[7:0];
            end
            default: glyph_s[4] = SEG_BLANK;
        endcase
    end

    // Next-state for scan, rotation, blink, buzzer and registered outputs.
    always_comb begin
        scan_cnt_d   = (scan_cnt_q == SCAN_LAST) ? '0 : scan_cnt_q + 1'b1;
        scan_idx_d   = (scan_cnt_q == SCAN_LAST) ? scan_idx_q + 3'd1 : scan_idx_q;
        rot_cnt_d    = rot_cnt_q;
        rot_player_d = rot_player_q;
        blink_d      = blink_q;
        last_state_d = bus.enable ? bus.state : last_state_q;

        if (entry_s) begin
            rot_cnt_d    = '0;
            rot_player_d = 4'd1;
        end else if (bus.enable && (bus.state == ST_FINISH)) begin
            if (rot_cnt_q == ROT_LAST) begin
                rot_cnt_d    = '0;
                rot_player_d = (rot_player_q >= PLAYERS_L) ? 4'd1 : rot_player_q + 4'd1;
            end else begin
                rot_cnt_d    = rot_cnt_q + 1'b1;
            end
            blink_d = ((rot_cnt_q == ROT_HALF) || (rot_cnt_q == ROT_LAST)) ? ~blink_q : blink_q;
        end else begin
            rot_cnt_d = rot_cnt_q;
        end

        if (!bus.enable) begin
            beep_cnt_d = '0;
        end else if (entry_s) begin
            beep_cnt_d = BEEP_LONG;
        end else if (short_trig_s) begin
            beep_cnt_d = BEEP_SHORT;
        end else if (beep_cnt_q != '0) begin
            beep_cnt_d = beep_cnt_q - 1'b1;
        end else begin
            beep_cnt_d = '0;
        end

        buzzer_d  = (beep_cnt_d != '0);
        seg_en_d  = bus.enable ? ~(8'd1 << scan_idx_q) : 8'hFF;
        seg_out_d = bus.enable ? glyph_s[scan_idx_q] : SEG_BLANK;
        led_d     = bus.enable ? led_s : '0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_q   <= '0;
            scan_idx_q   <= 3'd0;
            rot_cnt_q    <= '0;
            rot_player_q <= 4'd1;
            blink_q      <= 1'b0;
            beep_cnt_q   <= '0;
            last_state_q <= 3'd0;
            seg_out_q    <= 8'hFF;
            seg_en_q     <= 8'hFF;
            led_q        <= '0;
            buzzer_q     <= 1'b0;
        end else begin
            scan_cnt_q   <= scan_cnt_d;
            scan_idx_q   <= scan_idx_d;
            rot_cnt_q    <= rot_cnt_d;
            rot_player_q <= rot_player_d;
            blink_q      <= blink_d;
            beep_cnt_q   <= beep_cnt_d;
            last_state_q <= last_state_d;
            seg_out_q    <= seg_out_d;
            seg_en_q     <= seg_en_d;
            led_q        <= led_d;
            buzzer_q     <= buzzer_d;
        end
    end

    assign bus.seg_out = seg_out_q;
    assign bus.seg_en  = seg_en_q;
    assign bus.led     = led_q;
    assign bus.buzzer  = buzzer_q;

endmodule

// File: tb/tb_competition_view_multi.sv
// Bench for competition_view_multi: directed round scenarios plus random
// stimulus, every output compared each cycle against a behavioural model.
module tb_competition_view_multi;
    localparam int PLAYERS  = 4;
    localparam int SCORE_W  = 10;
    localparam int TIME_W   = 18;
    localparam int SCAN_DIV = 4;
    localparam int ROT_DIV  = 8;
    localparam int BEEP_LEN = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    competition_view_multi_if #(.PLAYERS(PLAYERS), .SCORE_W(SCORE_W), .TIME_W(TIME_W)) bus ();

    competition_view_multi #(
        .PLAYERS(PLAYERS), .SCORE_W(SCORE_W), .TIME_W(TIME_W),
        .SCAN_DIV(SCAN_DIV), .ROT_DIV(ROT_DIV), .BEEP_LEN(BEEP_LEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model state, in terms of elapsed cycles rather than counters.
    int sc [PLAYERS];
    int edges_done;
    int rticks;
    int last_st;
    int beep_end;
    bit blink;
    logic [7:0]         e_seg_out;
    logic [7:0]         e_seg_en;
    logic [PLAYERS-1:0] e_led;
    logic               e_buz;

    function automatic logic [7:0] seg_of(input int d);
        logic [7:0] tbl [16];
        tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        if (d < 0) return 8'hFF;
        return tbl[d];
    endfunction

    function automatic int digit_at(input int idx, input int prot);
        int g [8];
        int st, pc, sp, v, s;
        st = int'(bus.state);
        pc = int'(bus.play_count);
        sp = int'(bus.select_player);
        for (int i = 0; i < 8; i++) g[i] = -1;
        g[0] = 12;
        g[1] = pc;
        g[2] = (st <= 3) ? st + 10 : -1;
        v = -1;
        if (st == 0 && pc != 0) begin
            if (sp == 0) g[4] = 0;
            else if (sp <= PLAYERS) begin
                g[4] = sp;
                v = sc[sp-1];
            end
        end else if (st == 1) begin
            s = int'(bus.time_remain) / 1000;
            if (s > 99) s = 99;
            g[6] = s / 10;
            g[7] = s % 10;
        end else if (st == 2) begin
            if (sp >= 1 && sp <= PLAYERS) g[4] = sp;
        end else if (st == 3) begin
            g[4] = prot;
            v = sc[prot-1];
        end
        if (v >= 0) begin
            if (v > 999) v = 999;
            g[5] = (v >= 100) ? v / 100 : -1;
            g[6] = (v >= 10) ? (v / 10) % 10 : -1;
            g[7] = v % 10;
        end
        return g[idx];
    endfunction

    function automatic logic [PLAYERS-1:0] led_model(input int st);
        int sp, w;
        logic [PLAYERS-1:0] l;
        sp = int'(bus.select_player);
        w  = int'(bus.winner);
        l  = '0;
        if ((st == 0 || st == 2) && sp >= 1 && sp <= PLAYERS) l[sp-1] = 1'b1;
        if (st == 3 && w >= 1 && w <= PLAYERS) l[w-1] = blink;
        return l;
    endfunction

    task automatic model_edge();
        int st, idx, prot;
        bit en, entry;
        if (rst) begin
            edges_done = 0; rticks = 0; last_st = 0; beep_end = 0; blink = 1'b0;
            e_seg_out = 8'hFF; e_seg_en = 8'hFF; e_led = '0; e_buz = 1'b0;
            return;
        end
        st    = int'(bus.state);
        en    = bus.enable;
        idx   = (edges_done / SCAN_DIV) % 8;
        entry = en && st == 3 && last_st != 3;
        prot  = entry ? 1 : (rticks / ROT_DIV) % PLAYERS + 1;
        if (en) begin
            e_seg_en  = ~(8'd1 << idx);
            e_seg_out = seg_of(digit_at(idx, prot));
            e_led     = led_model(st);
        end else begin
            e_seg_en  = 8'hFF;
            e_seg_out = 8'hFF;
            e_led     = '0;
        end
        edges_done++;
        if (!en) beep_end = 0;
        else if (entry) beep_end = edges_done + 2 * BEEP_LEN;
        else if ((last_st == 0 && st == 1) || (last_st == 1 && st == 2)) beep_end = edges_done + BEEP_LEN;
        e_buz = (edges_done < beep_end);
        if (en && st == 3) begin
            if (entry) rticks = 0;
            else begin
                rticks++;
                if (rticks % (ROT_DIV / 2) == 0) blink = !blink;
            end
        end
        if (en) last_st = st;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_val("seg_en",  32'(bus.seg_en),  32'(e_seg_en));
        check_val("seg_out", 32'(bus.seg_out), 32'(e_seg_out));
        check_val("led",     32'(bus.led),     32'(e_led));
        check_val("buzzer",  32'(bus.buzzer),  32'(e_buz));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_scores(input int a, input int b, input int c, input int d);
        sc[0] = a; sc[1] = b; sc[2] = c; sc[3] = d;
        for (int k = 0; k < PLAYERS; k++) bus.scores[k*SCORE_W +: SCORE_W] = SCORE_W'(sc[k]);
    endtask

    initial begin
        rst = 1'b1;
        bus.enable = 1'b1; bus.play_count = 4'd3; bus.state = 3'd0;
        bus.time_remain = '0; bus.select_player = 4'd2; bus.winner = 4'd0;
        set_scores(5, 57, 0, 99);
        run(2);
        rst = 1'b0;
        run(34);
        // Answering: seconds clamp, then single digit with leading zero.
        bus.state = 3'd1; bus.time_remain = 18'd125400;
        run(36);
        bus.time_remain = 18'd7900;
        run(36);
        // Judging with a restarted pulse, then back to select without a beep.
        bus.state = 3'd2; run(2);
        bus.state = 3'd1; run(2);
        bus.state = 3'd2; run(10);
        bus.state = 3'd0; run(10);
        // Finished: rotation and winner blink.
        bus.state = 3'd2; run(2);
        set_scores(5, 120, 0, 99);
        bus.winner = 4'd3; bus.state = 3'd3;
        run(80);
        // Out-of-range player, then disable mid-beep and re-enable.
        bus.state = 3'd0; bus.select_player = 4'd6; run(34);
        bus.state = 3'd1; run(2);
        bus.enable = 1'b0; run(5);
        bus.enable = 1'b1; run(20);
        // Reset in the middle of a finished-state beep.
        bus.state = 3'd3; run(5);
        rst = 1'b1; run(1);
        rst = 1'b0; run(20);
        // Score clamping and leading-zero boundaries.
        set_scores(1023, 999, 100, 10);
        bus.state = 3'd0; run(2);
        bus.state = 3'd3; run(140);
        bus.play_count = 4'd0; bus.state = 3'd0; run(34);
        bus.state = 3'd5; run(34);
        for (int c = 0; c < 3000; c++) begin
            int r;
            if ($urandom_range(7) == 0) begin
                r = int'($urandom_range(11));
                bus.state = 3'((r < 8) ? r % 4 : r - 4);
            end
            if ($urandom_range(15) == 0) bus.select_player = 4'($urandom_range(9));
            if ($urandom_range(15) == 0) bus.winner = 4'($urandom_range(9));
            if ($urandom_range(31) == 0) bus.play_count = 4'($urandom_range(15));
            if ($urandom_range(7) == 0) bus.time_remain = 18'($urandom_range(262143));
            if ($urandom_range(31) == 0)
                set_scores(int'($urandom_range(1023)), int'($urandom_range(1023)),
                           int'($urandom_range(150)), int'($urandom_range(9)));
            bus.enable = ($urandom_range(19) != 0);
            rst = ($urandom_range(199) == 0);
            step();
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/competition_view_multi.md
Name: competition_view_multi

Overview:
Parametrised successor to the competition display view. It drives the 8-digit multiplexed seven-segment display, per-player LEDs and the buzzer during a quiz round, for a configurable player count. New relative to the current view: built-in digit scanning, a "finished" state (3) that rotates through all scores and blinks the winner LED, 3-digit scores with leading-zero suppression, seconds clamping, and a length-controlled buzzer pulse. It sits under the top-level view mux and is active when enable=1.

Parameters:
PLAYERS, 4, number of players (1..9).
SCORE_W, 7, score width per player in bits.
TIME_W, 18, width of time_remain in milliseconds.
SCAN_DIV, 100000, clk cycles per digit slot.
ROT_DIV, 100000000, clk cycles per score rotation step in state 3; the winner LED toggles every ROT_DIV/2.
BEEP_LEN, 20000000, buzzer pulse length in clk cycles.

Ports:
clk  in  1  system clock (single clock domain).
rst  in  1  synchronous, active-high reset.
enable  in  1  view is selected.
play_count  in  4  round number, shown as a hex digit.
state  in  3  0=select, 1=answering, 2=judging, 3=finished.
time_remain  in  TIME_W  remaining answer time in ms.
scores  in  PLAYERS*SCORE_W  player k (1-based) occupies bits [k*SCORE_W-1 -: SCORE_W].
select_player  in  4  0=none, 1..PLAYERS=player.
winner  in  4  0=none, 1..PLAYERS=player.
seg_out  out  8  active-low segments, bcd_seg encoding; blank=8'hFF.
seg_en  out  8  active-low one-hot digit enable.
led  out  PLAYERS  led[k-1] lit for player k.
buzzer  out  1  high during an alert pulse.

Behaviour:
- Reset (rst=1 at a clk edge): scan_idx=0, scan_cnt=0, rot_cnt=0, rot_player=1, blink=0, beep_cnt=0, last_state=0. Outputs: seg_out=8'hFF, seg_en=8'hFF, led=0, buzzer=0. Reset takes priority over every other event.
- Scan: scan_cnt counts 0..SCAN_DIV-1. On wrap, scan_idx increments modulo 8.
- seg_en and seg_out are registered: one cycle after scan_idx changes, seg_en=~(1<<scan_idx) and seg_out=glyph[scan_idx].
- enable=0: seg_en=8'hFF, led=0, buzzer=0, beep_cnt cleared. last_state and rot state are held. Scan counters keep running.
- Glyphs: d0=8'hC6 ('C'). d1=hex(play_count). d2=hex(state+10) for state<=3, else blank. d3=blank.
- state 0: d4..d7 blank when play_count=0. Otherwise: select_player=0 shows d4='0' with d5..d7 blank; 1..PLAYERS shows d4=player and d5..d7=score; >PLAYERS shows d4..d7 blank.
- state 1: d4, d5 blank. d6..d7 = min(time_remain/1000, 99) as 2 digits, with the tens digit always shown.
- state 2: d4=select_player when it is 1..PLAYERS, else blank. d5..d7 blank.
- state 3: d4=rot_player, d5..d7=score of rot_player. rot_cnt wraps at ROT_DIV, then rot_player advances 1..PLAYERS and wraps back to 1. Entering state 3 reloads rot_player=1 and rot_cnt=0.
- state 4..7: d4..d7 blank.
- Score digits: value clamped to 999. Hundreds shown only when nonzero. Tens shown only when hundreds or tens is nonzero. Units always shown.
- LEDs: in states 0 and 2, led[select_player-1]=1 for a valid player. In state 3, led[winner-1]=blink, and blink toggles every ROT_DIV/2. Otherwise led=0.
- Buzzer: sampled only while enable=1. last_state<=state every cycle.
- Transitions 0->1 and 1->2 load beep_cnt=BEEP_LEN. Transition to 3 from any other state loads 2*BEEP_LEN.
- buzzer=(beep_cnt!=0), asserting the cycle after the transition edge. beep_cnt decrements to 0.
- A new trigger during an active pulse reloads the counter (restart, not extend).
- Transitions 2->0, 3->0 and any transition into 4..7 give no beep.
- Arithmetic: divide/modulo are combinational on clamped values. Out-of-range select_player or winner never indexes out of bounds.

Test Plan:
- Reset then enable=1, play_count=3, state=0, select_player=2, P2 score=57 (SCAN_DIV=4) -> over 32 cycles seg_en walks FE,FD,…,7F. Glyphs are C,3,A,blank,2,blank,5,7. led=4'b0010.
- state=1, time_remain=125400 -> d6..d7 = "99". Then time_remain=7900 -> "07". The 0->1 edge gives buzzer high exactly BEEP_LEN cycles starting the next cycle.
- state 1->2 at cycle t, then 2->1->2 within the pulse -> buzzer stays high until the last reload + BEEP_LEN. 2->0 gives no beep.
- state 2->3, winner=3, scores 5,120,0,99 (ROT_DIV=8) -> buzzer high 2*BEEP_LEN. Display cycles "1 5", "2 120", "3 0", "4 99", then back to 1. led[2] toggles every 4 cycles.
- select_player=6 with PLAYERS=4 -> d4..d7 blank, led=0. enable=0 mid-beep -> seg_en=FF and buzzer=0 immediately (registered). Re-enable -> no spurious beep.
- rst asserted mid-beep in state 3 -> next cycle all outputs at reset values, rot_player=1.
